// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - execute-stage branch resolver with BTB and direction counters
module branch_resolve_unit #(
    parameter int XLEN     = 64,
    parameter int ENTRIES  = 16,
    parameter int CNT_BITS = 2,
    parameter int CNT_INIT = 1
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic [XLEN-1:0] i_if_pc,
    output logic            o_pred_taken,
    output logic [XLEN-1:0] o_pred_target,
    input  logic            i_ex_valid,
    input  logic            i_ex_stall,
    input  logic [1:0]      i_ex_kind,
    input  logic            i_ex_cond,
    input  logic [31:0]     i_ex_instr,
    input  logic [XLEN-1:0] i_ex_pc,
    input  logic [XLEN-1:0] i_ex_rs1_sum,
    input  logic            i_ex_pred_taken,
    input  logic [XLEN-1:0] i_ex_pred_target,
    output logic            o_redirect_valid,
    output logic [XLEN-1:0] o_redirect_pc,
    output logic            o_misalign,
    output logic [31:0]     o_mispredict_cnt
);
    localparam int IW = $clog2(ENTRIES);
    localparam int TW = XLEN - IW - 2;
    localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
    localparam logic [CNT_BITS-1:0] CNT_WT  = CNT_BITS'(1 << (CNT_BITS - 1));
    localparam logic [CNT_BITS-1:0] CNT_RST = CNT_BITS'(CNT_INIT);

    logic                r_valid  [ENTRIES];
    logic [TW-1:0]       r_tag    [ENTRIES];
    logic [XLEN-1:0]     r_target [ENTRIES];
    logic                r_uncond [ENTRIES];
    logic [CNT_BITS-1:0] r_cnt    [ENTRIES];

    logic            r_redirect_valid;
    logic [XLEN-1:0] r_redirect_pc;
    logic            r_misalign;
    logic [31:0]     r_mispredict_cnt;

    logic [IW-1:0]   w_lk_idx;
    logic [TW-1:0]   w_lk_tag;
    logic            w_lk_hit;
    logic [IW-1:0]   w_ex_idx;
    logic [TW-1:0]   w_ex_tag;
    logic            w_ex_hit;
    logic [XLEN-1:0] w_jimm;
    logic [XLEN-1:0] w_bimm;
    logic            w_resolve;
    logic            w_taken;
    logic [XLEN-1:0] w_target;
    logic [XLEN-1:0] w_next_pc;
    logic            w_mispredict;
    logic            w_misalign_now;
    logic            w_fire;
    logic            w_train;
    logic            w_unused;

    // Fetch-side lookup reads the pre-write table contents.
    assign w_lk_idx      = i_if_pc[IW+1:2];
    assign w_lk_tag      = i_if_pc[XLEN-1:IW+2];
    assign w_lk_hit      = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
    assign o_pred_taken  = w_lk_hit && (r_uncond[w_lk_idx] || r_cnt[w_lk_idx][CNT_BITS-1]);
    assign o_pred_target = w_lk_hit ? r_target[w_lk_idx] : i_if_pc + XLEN'(4);

    assign w_ex_idx = i_ex_pc[IW+1:2];
    assign w_ex_tag = i_ex_pc[XLEN-1:IW+2];
    assign w_ex_hit = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);

    assign w_jimm = {{(XLEN-21){i_ex_instr[31]}}, i_ex_instr[31], i_ex_instr[19:12],
                     i_ex_instr[20], i_ex_instr[30:21], 1'b0};
    assign w_bimm = {{(XLEN-13){i_ex_instr[31]}}, i_ex_instr[31], i_ex_instr[7],
                     i_ex_instr[30:25], i_ex_instr[11:8], 1'b0};

    // Instructions in the redirect cycle are wrong-path and are ignored.
    assign w_resolve = i_ex_valid && !i_ex_stall && (i_ex_kind != 2'b00) && !r_redirect_valid;

    always_comb begin
        w_taken  = 1'b0;
        w_target = i_ex_pc + w_bimm;
        case (i_ex_kind)
            2'b01: begin
                w_taken  = 1'b1;
                w_target = i_ex_pc + w_jimm;
            end
            2'b10: begin
                w_taken  = 1'b1;
                w_target = {i_ex_rs1_sum[XLEN-1:1], 1'b0};
            end
            2'b11: w_taken = i_ex_cond;
            default: w_taken = 1'b0;
        endcase
    end

    assign w_next_pc      = w_taken ? w_target : i_ex_pc + XLEN'(4);
    assign w_mispredict   = w_resolve && ((w_taken != i_ex_pred_taken) ||
                            (w_taken && (w_target != i_ex_pred_target)));
    assign w_misalign_now = w_resolve && w_taken && (w_target[1:0] != 2'b00);
    assign w_fire         = w_mispredict || w_misalign_now;
    assign w_train        = w_resolve && !w_misalign_now;
    assign w_unused       = ^{i_ex_instr[6:0], i_ex_rs1_sum[0]};

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_uncond[i] <= 1'b0;
                r_cnt[i]    <= CNT_RST;
            end
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
            r_misalign       <= 1'b0;
            r_mispredict_cnt <= '0;
        end else begin
            r_redirect_valid <= w_fire;
            r_misalign       <= w_fire && w_misalign_now;
            if (w_fire)
                r_redirect_pc <= w_next_pc;
            if (w_mispredict)
                r_mispredict_cnt <= r_mispredict_cnt + 32'd1;
            if (w_train) begin
                if (w_ex_hit) begin
                    if (w_taken) begin
                        r_target[w_ex_idx] <= w_target;
                        if (r_cnt[w_ex_idx] != CNT_MAX)
                            r_cnt[w_ex_idx] <= r_cnt[w_ex_idx] + CNT_BITS'(1);
                    end else if (r_cnt[w_ex_idx] != '0) begin
                        r_cnt[w_ex_idx] <= r_cnt[w_ex_idx] - CNT_BITS'(1);
                    end
                end else if (w_taken) begin
                    r_valid[w_ex_idx]  <= 1'b1;
                    r_tag[w_ex_idx]    <= w_ex_tag;
                    r_target[w_ex_idx] <= w_target;
                    r_uncond[w_ex_idx] <= (i_ex_kind != 2'b11);
                    r_cnt[w_ex_idx]    <= CNT_WT;
                end
            end
        end
    end

    assign o_redirect_valid = r_redirect_valid;
    assign o_redirect_pc    = r_redirect_pc;
    assign o_misalign       = r_misalign;
    assign o_mispredict_cnt = r_mispredict_cnt;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - self-checking bench for branch_resolve_unit
module tb_branch_resolve_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] if_pc;
    logic        pred_taken;
    logic [63:0] pred_target;
    logic        ex_valid, ex_stall, ex_cond, ex_pred_taken;
    logic [1:0]  ex_kind;
    logic [31:0] ex_instr;
    logic [63:0] ex_pc, ex_rs1_sum, ex_pred_target;
    logic        redirect_valid, misalign;
    logic [63:0] redirect_pc;
    logic [31:0] mispredict_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    branch_resolve_unit dut (
        .i_clk(clk), .i_reset(rst_n), .i_if_pc(if_pc),
        .o_pred_taken(pred_taken), .o_pred_target(pred_target),
        .i_ex_valid(ex_valid), .i_ex_stall(ex_stall), .i_ex_kind(ex_kind),
        .i_ex_cond(ex_cond), .i_ex_instr(ex_instr), .i_ex_pc(ex_pc),
        .i_ex_rs1_sum(ex_rs1_sum), .i_ex_pred_taken(ex_pred_taken),
        .i_ex_pred_target(ex_pred_target), .o_redirect_valid(redirect_valid),
        .o_redirect_pc(redirect_pc), .o_misalign(misalign),
        .o_mispredict_cnt(mispredict_cnt)
    );

    function automatic logic [31:0] enc_j(input logic [20:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd0, 7'h6F};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm);
        return {imm[12], imm[10:5], 5'd3, 5'd2, 3'd0, imm[4:1], imm[11], 7'h63};
    endfunction

    task automatic drive(input logic v, input logic s, input logic [1:0] k, input logic c,
                         input logic [31:0] ins, input logic [63:0] p, input logic [63:0] r,
                         input logic pt, input logic [63:0] ptg);
        ex_valid = v; ex_stall = s; ex_kind = k; ex_cond = c; ex_instr = ins;
        ex_pc = p; ex_rs1_sum = r; ex_pred_taken = pt; ex_pred_target = ptg;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 64'd0, 64'd0, 1'b0, 64'd0);
    endtask

    task automatic bubble();
        @(negedge clk); idle();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        idle(); if_pc = 64'h1000; rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rv got %0b want 0", redirect_valid); end
        n_tests++; if (redirect_pc !== 64'd0) begin n_fail++; $display("FAIL reset_rpc got %h want 0", redirect_pc); end
        n_tests++; if (misalign !== 1'b0) begin n_fail++; $display("FAIL reset_mis got %0b want 0", misalign); end
        n_tests++; if (mispredict_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_cnt got %0d want 0", mispredict_cnt); end
        n_tests++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL reset_pt got %0b want 0", pred_taken); end
        n_tests++; if (pred_target !== 64'h1004) begin n_fail++; $display("FAIL reset_ptgt got %h want 1004", pred_target); end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_jal();
        @(negedge clk); drive(1, 0, 2'b01, 0, 32'h0080006F, 64'h1000, 0, 0, 0);
        @(posedge clk); #1;
        n_tests++; if (redirect_valid !== 1'b1) begin n_fail++; $display("FAIL jal_rv got %0b want 1", redirect_valid); end
        n_tests++; if (redirect_pc !== 64'h1008) begin n_fail++; $display("FAIL jal_rpc got %h want 1008", redirect_pc); end
        n_tests++; if (mispredict_cnt !== 32'd1) begin n_fail++; $display("FAIL jal_cnt got %0d want 1", mispredict_cnt); end
        @(negedge clk); idle(); if_pc = 64'h1000; #1;
        n_tests++; if (pred_taken !== 1'b1) begin n_fail++; $display("FAIL jal_lk_pt got %0b want 1", pred_taken); end
        n_tests++; if (pred_target !== 64'h1008) begin n_fail++; $display("FAIL jal_lk_tgt got %h want 1008", pred_target); end
        @(posedge clk); #1;
        n_tests++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL jal_rv_clear got %0b want 0", redirect_valid); end
    endtask

    task automatic test_branch_saturate();
        logic [31:0] beq;
        beq = enc_b(13'h1FFC);
        @(negedge clk); drive(1, 0, 2'b11, 1, beq, 64'h2000, 0, 0, 0);
        @(posedge clk); #1;
        n_tests++; if (redirect_valid !== 1'b1 || redirect_pc !== 64'h1FFC) begin n_fail++; $display("FAIL beq_first got rv=%0b pc=%h want rv=1 pc=1ffc", redirect_valid, redirect_pc); end
        bubble();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); drive(1, 0, 2'b11, 1, beq, 64'h2000, 0, 1, 64'h1FFC);
            @(posedge clk); #1;
            n_tests++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL beq_correct%0d got rv=%0b want 0", i, redirect_valid); end
        end
        @(negedge clk); drive(1, 0, 2'b11, 0, beq, 64'h2000, 0, 1, 64'h1FFC);
        @(posedge clk); #1;
        n_tests++; if (redirect_valid !== 1'b1 || redirect_pc !== 64'h2004) begin n_fail++; $display("FAIL beq_nt got rv=%0b pc=%h want rv=1 pc=2004", redirect_valid, redirect_pc); end
        n_tests++; if (mispredict_cnt !== 32'd3) begin n_fail++; $display("FAIL beq_cnt got %0d want 3", mispredict_cnt); end
        @(negedge clk); idle(); if_pc = 64'h2000; #1;
        n_tests++; if (pred_taken !== 1'b1 || pred_target !== 64'h1FFC) begin n_fail++; $display("FAIL beq_lk_ctr2 got pt=%0b tgt=%h want pt=1 tgt=1ffc", pred_taken, pred_target); end
        @(posedge clk); #1;
        @(negedge clk); drive(1, 0, 2'b11, 0, beq, 64'h2000, 0, 1, 64'h1FFC);
        @(posedge clk); #1;
        n_tests++; if (mispredict_cnt !== 32'd4) begin n_fail++; $display("FAIL beq_cnt2 got %0d want 4", mispredict_cnt); end
        @(negedge clk); idle(); if_pc = 64'h2000; #1;
        n_tests++; if (pred_taken !== 1'b0 || pred_target !== 64'h1FFC) begin n_fail++; $display("FAIL beq_lk_ctr1 got pt=%0b tgt=%h want pt=0 tgt=1ffc", pred_taken, pred_target); end
        @(posedge clk); #1;
    endtask

    task automatic test_jalr_misalign();
        @(negedge clk); drive(1, 0, 2'b10, 0, 32'h000080E7, 64'h3100, 64'h3001, 0, 0);
        @(posedge clk); #1;
        n_tests++; if (redirect_valid !== 1'b1 || redirect_pc !== 64'h3000 || misalign !== 1'b0) begin n_fail++; $display("FAIL jalr_bit0 got rv=%0b pc=%h mis=%0b want 1/3000/0", redirect_valid, redirect_pc, misalign); end
        n_tests++; if (mispredict_cnt !== 32'd5) begin n_fail++; $display("FAIL jalr_cnt got %0d want 5", mispredict_cnt); end
        bubble();
        @(negedge clk); drive(1, 0, 2'b10, 0, 32'h000080E7, 64'h3100, 64'h3002, 1, 64'h3002);
        @(posedge clk); #1;
        n_tests++; if (redirect_valid !== 1'b1 || redirect_pc !== 64'h3002 || misalign !== 1'b1) begin n_fail++; $display("FAIL jalr_mis got rv=%0b pc=%h mis=%0b want 1/3002/1", redirect_valid, redirect_pc, misalign); end
        n_tests++; if (mispredict_cnt !== 32'd5) begin n_fail++; $display("FAIL jalr_mis_cnt got %0d want 5", mispredict_cnt); end
        @(negedge clk); idle(); if_pc = 64'h3100; #1;
        n_tests++; if (pred_taken !== 1'b1 || pred_target !== 64'h3000) begin n_fail++; $display("FAIL jalr_no_train got pt=%0b tgt=%h want 1/3000", pred_taken, pred_target); end
        @(posedge clk); #1;
        n_tests++; if (misalign !== 1'b0 || redirect_valid !== 1'b0) begin n_fail++; $display("FAIL jalr_mis_clear got mis=%0b rv=%0b want 0/0", misalign, redirect_valid); end
    endtask

    task automatic test_wrong_path();
        @(negedge clk); drive(1, 0, 2'b01, 0, enc_j(21'd8), 64'h4000, 0, 0, 0);
        @(posedge clk); #1;
        n_tests++; if (redirect_valid !== 1'b1 || mispredict_cnt !== 32'd6) begin n_fail++; $display("FAIL wp_first got rv=%0b cnt=%0d want 1/6", redirect_valid, mispredict_cnt); end
        @(negedge clk); drive(1, 0, 2'b01, 0, enc_j(21'd16), 64'h5000, 0, 0, 0);
        @(posedge clk); #1;
        n_tests++; if (redirect_valid !== 1'b0 || mispredict_cnt !== 32'd6) begin n_fail++; $display("FAIL wp_second got rv=%0b cnt=%0d want 0/6", redirect_valid, mispredict_cnt); end
        @(negedge clk); idle(); if_pc = 64'h5000; #1;
        n_tests++; if (pred_taken !== 1'b0 || pred_target !== 64'h5004) begin n_fail++; $display("FAIL wp_no_train got pt=%0b tgt=%h want 0/5004", pred_taken, pred_target); end
        if_pc = 64'h4000; #1;
        n_tests++; if (pred_taken !== 1'b1 || pred_target !== 64'h4008) begin n_fail++; $display("FAIL wp_trained got pt=%0b tgt=%h want 1/4008", pred_taken, pred_target); end
        @(posedge clk); #1;
    endtask

    task automatic test_stall_reset();
        @(negedge clk); drive(1, 1, 2'b01, 0, enc_j(21'd8), 64'h6000, 0, 0, 0);
        @(posedge clk); #1;
        n_tests++; if (redirect_valid !== 1'b0 || mispredict_cnt !== 32'd6) begin n_fail++; $display("FAIL stall_held got rv=%0b cnt=%0d want 0/6", redirect_valid, mispredict_cnt); end
        @(negedge clk); ex_stall = 1'b0;
        @(posedge clk); #1;
        n_tests++; if (redirect_valid !== 1'b1 || redirect_pc !== 64'h6008 || mispredict_cnt !== 32'd7) begin n_fail++; $display("FAIL stall_release got rv=%0b pc=%h cnt=%0d want 1/6008/7", redirect_valid, redirect_pc, mispredict_cnt); end
        #2; idle(); if_pc = 64'h6000; rst_n = 1'b0; #1;
        n_tests++; if (redirect_valid !== 1'b0 || redirect_pc !== 64'd0 || misalign !== 1'b0 || mispredict_cnt !== 32'd0) begin n_fail++; $display("FAIL async_reset got rv=%0b pc=%h mis=%0b cnt=%0d want all 0", redirect_valid, redirect_pc, misalign, mispredict_cnt); end
        n_tests++; if (pred_taken !== 1'b0 || pred_target !== 64'h6004) begin n_fail++; $display("FAIL async_reset_btb got pt=%0b tgt=%h want 0/6004", pred_taken, pred_target); end
        @(negedge clk); rst_n = 1'b1;
    endtask

    logic        m_v   [16];
    logic [63:0] m_tag [16];
    logic [63:0] m_tgt [16];
    logic        m_u   [16];
    int          m_c   [16];
    logic        m_rv, m_mis;
    logic [63:0] m_rpc;
    logic [31:0] m_cnt;

    function automatic int slot_of(input logic [63:0] pc);
        return int'((pc >> 2) % 64'd16);
    endfunction

    function automatic logic m_hit(input logic [63:0] pc);
        return m_v[slot_of(pc)] && (m_tag[slot_of(pc)] == (pc >> 6));
    endfunction

    task automatic test_random();
        logic [63:0] pcs [8];
        logic [63:0] p, rs1, tgt, nxt, ptg, exp_tgt;
        logic        v, s, c, pt, tk, res, mp, mal, exp_pt;
        logic [1:0]  k;
        logic [31:0] ins;
        longint      ji, bi;
        int          sl;
        for (int i = 0; i < 4; i++) begin
            pcs[i]   = 64'h8000 + 64'(i * 4);
            pcs[i+4] = 64'h9000 + 64'(i * 4);
        end
        idle(); rst_n = 1'b0; #3; rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            m_v[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_u[i] = 0; m_c[i] = 1;
        end
        m_rv = 0; m_mis = 0; m_rpc = 0; m_cnt = 0;
        for (int it = 0; it < 400; it++) begin
            @(negedge clk);
            if_pc = pcs[$urandom_range(0, 7)];
            v   = ($urandom_range(0, 3) != 0);
            s   = ($urandom_range(0, 7) == 0);
            k   = 2'($urandom_range(0, 3));
            c   = 1'($urandom_range(0, 1));
            p   = pcs[$urandom_range(0, 7)];
            rs1 = 64'h7000 + 64'($urandom_range(0, 7));
            ji  = longint'($urandom_range(0, 64)) * 2 - 64;
            bi  = longint'($urandom_range(0, 64)) * 2 - 64;
            ins = (k == 2'b01) ? enc_j(ji[20:0]) : (k == 2'b11) ? enc_b(bi[12:0]) : $urandom;
            if ($urandom_range(0, 1) == 1) begin
                sl = slot_of(p);
                pt  = m_hit(p) && (m_u[sl] || m_c[sl] >= 2);
                ptg = m_hit(p) ? m_tgt[sl] : p + 4;
            end else begin
                pt  = 1'($urandom_range(0, 1));
                ptg = p + 64'($urandom_range(0, 3) * 4);
            end
            drive(v, s, k, c, ins, p, rs1, pt, ptg);
            #1;
            sl = slot_of(if_pc);
            exp_pt  = m_hit(if_pc) && (m_u[sl] || m_c[sl] >= 2);
            exp_tgt = m_hit(if_pc) ? m_tgt[sl] : if_pc + 4;
            n_tests++; if (pred_taken !== exp_pt || pred_target !== exp_tgt) begin n_fail++; $display("FAIL rnd_lookup it=%0d got pt=%0b tgt=%h want pt=%0b tgt=%h", it, pred_taken, pred_target, exp_pt, exp_tgt); end
            res = v && !s && (k != 0) && !m_rv;
            case (k)
                2'b01:   begin tk = 1; tgt = p + ji; end
                2'b10:   begin tk = 1; tgt = rs1 & ~64'd1; end
                default: begin tk = c; tgt = p + bi; end
            endcase
            mp  = res && ((tk != pt) || (tk && tgt != ptg));
            mal = res && tk && (tgt % 4 != 0);
            nxt = tk ? tgt : p + 4;
            @(posedge clk); #1;
            m_rv = mp || mal;
            if (m_rv) m_rpc = nxt;
            m_mis = m_rv && mal;
            if (mp) m_cnt = m_cnt + 1;
            sl = slot_of(p);
            if (res && !mal) begin
                if (m_hit(p)) begin
                    if (tk) begin m_tgt[sl] = tgt; m_c[sl] = (m_c[sl] < 3) ? m_c[sl] + 1 : 3; end
                    else m_c[sl] = (m_c[sl] > 0) ? m_c[sl] - 1 : 0;
                end else if (tk) begin
                    m_v[sl] = 1; m_tag[sl] = p >> 6; m_tgt[sl] = tgt; m_u[sl] = (k != 2'b11); m_c[sl] = 2;
                end
            end
            n_tests++; if (redirect_valid !== m_rv || misalign !== m_mis || redirect_pc !== m_rpc || mispredict_cnt !== m_cnt) begin n_fail++; $display("FAIL rnd_resolve it=%0d got rv=%0b mis=%0b pc=%h cnt=%0d want rv=%0b mis=%0b pc=%h cnt=%0d", it, redirect_valid, misalign, redirect_pc, mispredict_cnt, m_rv, m_mis, m_rpc, m_cnt); end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        if_pc = 64'd0;
        idle();
        test_reset();
        test_jal();
        test_branch_saturate();
        test_jalr_misalign();
        test_wrong_path();
        test_stall_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
